// File: rtl/pi_loop_filter_gs.sv
// pi_loop_filter_gs: gear-shifted PI loop filter producing the ADPLL DCO code.
// Define PI_LF_GEAR_EN to add the boosted-gain ACQUIRE phase.
module pi_loop_filter_gs #(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 5,
  parameter int KP_WIDTH      = 5,
  parameter int KP_FRAC_WIDTH = 4,
  parameter int KI_WIDTH      = 11,
  parameter int KI_FRAC_WIDTH = 10,
  parameter int GEAR_SHIFT    = 2,
  parameter int ACQ_CYCLES    = 64,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic        [KP_WIDTH-1:0]     kp_i,
  input  logic        [KI_WIDTH-1:0]     ki_i,
  output logic        [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           locked_o,
  output logic        [1:0]              state_o
);
  localparam int KW   = (KP_WIDTH > KI_WIDTH) ? KP_WIDTH : KI_WIDTH;
  localparam int AW   = DCO_CC_WIDTH + KI_FRAC_WIDTH + 1;
  localparam int PW   = ERROR_WIDTH + KW + GEAR_SHIFT + 1;
  localparam int XW   = ((PW > AW) ? PW : AW) + 2;
  localparam int CNT  = (ACQ_CYCLES > LOCK_COUNT) ? ACQ_CYCLES : LOCK_COUNT;
  localparam int NW   = $clog2(CNT);
  localparam int MID  = 2 ** (DCO_CC_WIDTH - 1);
  localparam int MAXV = 2 ** DCO_CC_WIDTH - 1;
  localparam int AMAX = 2 ** (DCO_CC_WIDTH - 1 + KI_FRAC_WIDTH);
  localparam int EW1  = ERROR_WIDTH + 1;

  typedef enum logic [1:0] {
`ifdef PI_LF_GEAR_EN
    ST_ACQ = 2'd0,
`endif
    ST_TRK = 2'd1,
    ST_LCK = 2'd2
  } state_t;

`ifdef PI_LF_GEAR_EN
  localparam state_t ST_RST = ST_ACQ;
`else
  localparam state_t ST_RST = ST_TRK;
`endif

  state_t                   state_q, state_d;
  logic [NW-1:0]            lock_q, lock_d;
`ifdef PI_LF_GEAR_EN
  logic [NW-1:0]            acq_q, acq_d;
`endif
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [DCO_CC_WIDTH-1:0]  dco_q, dco_d;

  logic                     gear_on;
  int                       g;
  logic signed [XW-1:0]     e_x, kp_x, ki_x;
  logic signed [XW-1:0]     p_x, d_x, nxt_x, sum_x;
  logic [ERROR_WIDTH:0]     e_abs;
  logic                     e_neg, e_pos, hi, lo;
  logic                     in_lock, far;

`ifdef PI_LF_GEAR_EN
  assign gear_on = (state_q == ST_ACQ);
`else
  assign gear_on = 1'b0;
`endif

  always_comb begin
    g     = gear_on ? GEAR_SHIFT : 0;
    e_x   = XW'(error_i);
    kp_x  = XW'(kp_i);
    ki_x  = XW'(ki_i);
    p_x   = ((e_x * kp_x) <<< g) >>> KP_FRAC_WIDTH;
    d_x   = (e_x * ki_x) <<< g;
    nxt_x = XW'(acc_q) + d_x;
    sum_x = XW'(MID) + p_x + (nxt_x >>> KI_FRAC_WIDTH);
    e_neg = error_i[ERROR_WIDTH-1];
    e_pos = !e_neg && (error_i != '0);
    hi    = sum_x > XW'(MAXV);
    lo    = sum_x < XW'(0);
    if (hi)      dco_d = DCO_CC_WIDTH'(MAXV);
    else if (lo) dco_d = '0;
    else         dco_d = sum_x[DCO_CC_WIDTH-1:0];
    // freeze the integrator while the output is pinned in the error's direction
    if ((hi && e_pos) || (lo && e_neg)) acc_d = acc_q;
    else if (nxt_x > XW'(AMAX))         acc_d = AW'(AMAX);
    else if (nxt_x < XW'(-AMAX))        acc_d = AW'(-AMAX);
    else                                acc_d = nxt_x[AW-1:0];
    e_abs   = e_neg ? -{e_neg, error_i} : {e_neg, error_i};
    in_lock = e_abs <= EW1'(LOCK_THRESH);
    far     = e_abs > EW1'(4 * LOCK_THRESH);
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
`ifdef PI_LF_GEAR_EN
    acq_d   = acq_q;
`endif
    unique case (state_q)
`ifdef PI_LF_GEAR_EN
      ST_ACQ: begin
        acq_d = acq_q + NW'(1);
        if (acq_q == NW'(ACQ_CYCLES - 1)) begin
          state_d = ST_TRK;
          lock_d  = '0;
        end
      end
`endif
      ST_TRK: begin
        lock_d = in_lock ? lock_q + NW'(1) : '0;
        if (in_lock && lock_q == NW'(LOCK_COUNT - 1))
          state_d = ST_LCK;
      end
      ST_LCK: begin
        if (far) begin
`ifdef PI_LF_GEAR_EN
          state_d = ST_ACQ;
          acq_d   = '0;
`else
          state_d = ST_TRK;
          lock_d  = '0;
`endif
        end else if (!in_lock) begin
          state_d = ST_TRK;
          lock_d  = '0;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_RST;
      lock_q  <= '0;
`ifdef PI_LF_GEAR_EN
      acq_q   <= '0;
`endif
      acc_q   <= '0;
      dco_q   <= DCO_CC_WIDTH'(MID);
    end else if (enable_i) begin
      state_q <= state_d;
      lock_q  <= lock_d;
`ifdef PI_LF_GEAR_EN
      acq_q   <= acq_d;
`endif
      acc_q   <= acc_d;
      dco_q   <= dco_d;
    end
  end

  assign dco_cc_o = dco_q;
  assign locked_o = (state_q == ST_LCK);
  assign state_o  = state_q;
endmodule

// File: tb/tb_pi_loop_filter_gs.sv
// tb_pi_loop_filter_gs: directed vectors for the gear-shifted PI filter.
// Expected values follow whether PI_LF_GEAR_EN is defined for the build.
module tb_pi_loop_filter_gs;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic signed [7:0] err = '0;
  logic [4:0]        kp  = 5'd1;
  logic [10:0]       ki  = 11'd1;
  logic [4:0]        dco;
  logic              locked;
  logic [1:0]        st;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pi_loop_filter_gs dut (
    .gen_clk_i(clk),
    .reset_i  (rst),
    .enable_i (en),
    .error_i  (err),
    .kp_i     (kp),
    .ki_i     (ki),
    .dco_cc_o (dco),
    .locked_o (locked),
    .state_o  (st)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input int e_dco, input int e_acc,
                      input int e_st, input int e_lk);
    chk({tag, ".dco"}, int'(dco), e_dco);
    chk({tag, ".acc"}, int'(dut.acc_q), e_acc);
    chk({tag, ".state"}, int'(st), e_st);
    chk({tag, ".locked"}, int'(locked), e_lk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #2;
`ifdef PI_LF_GEAR_EN
    look("reset", 16, 0, 0, 0);
`else
    look("reset", 16, 0, 1, 0);
`endif
    rst = 1'b0;
    en  = 1'b1;
    err = 8'sd0;
`ifdef PI_LF_GEAR_EN
    tick(63); look("acq63", 16, 0, 0, 0);
    tick(1);  look("trk64", 16, 0, 1, 0);
    tick(15); look("trk79", 16, 0, 1, 0);
    tick(1);  look("lck80", 16, 0, 2, 1);
    err = 8'sd3; tick(1);  look("slip3", 16, 3, 1, 0);
    err = 8'sd0; tick(16); look("relock", 16, 3, 2, 1);
    err = 8'sd9; tick(1);  look("slip9", 16, 12, 0, 0);
    err = 8'sd0; tick(63); look("reacq63", 16, 12, 0, 0);
    tick(1); look("reacq64", 16, 12, 1, 0);
    rst = 1'b1; #1; look("async_rst", 16, 0, 0, 0);
    rst = 1'b0;
    err = 8'sd10; tick(1); look("e10_1", 18, 40, 0, 0);
    tick(25); look("e10_26", 19, 1040, 0, 0);
    rst = 1'b1; #1; look("async_rst2", 16, 0, 0, 0);
    rst = 1'b0;
    kp = 5'd31; ki = 11'd31;
    err = 8'sd127; tick(1); look("sat_hi", 31, 0, 0, 0);
    err = -8'sd1;  tick(1); look("unwind", 7, -124, 0, 0);
    en = 1'b0; err = 8'sd50; tick(20); look("hold", 7, -124, 0, 0);
    en = 1'b1; err = 8'sd0;  tick(1);  look("resume", 15, -124, 0, 0);
    tick(60); look("acq_held", 15, -124, 0, 0);
    tick(1);  look("acq_done", 15, -124, 1, 0);
`else
    tick(15); look("trk15", 16, 0, 1, 0);
    tick(1);  look("lck16", 16, 0, 2, 1);
    err = 8'sd3; tick(1);  look("slip3", 16, 3, 1, 0);
    err = 8'sd0; tick(16); look("relock", 16, 3, 2, 1);
    err = 8'sd9; tick(1);  look("slip9", 16, 12, 1, 0);
    err = 8'sd0; tick(15); look("retrk15", 16, 12, 1, 0);
    tick(1); look("relock2", 16, 12, 2, 1);
    rst = 1'b1; #1; look("async_rst", 16, 0, 1, 0);
    rst = 1'b0;
    err = 8'sd10; tick(1); look("e10_1", 16, 10, 1, 0);
    tick(102); look("e10_103", 17, 1030, 1, 0);
    rst = 1'b1; #1; look("async_rst2", 16, 0, 1, 0);
    rst = 1'b0;
    kp = 5'd31; ki = 11'd31;
    err = 8'sd127; tick(1); look("sat_hi", 31, 0, 1, 0);
    err = -8'sd1;  tick(1); look("unwind", 13, -31, 1, 0);
    en = 1'b0; err = 8'sd50; tick(20); look("hold", 13, -31, 1, 0);
    en = 1'b1; err = 8'sd0;  tick(1);  look("resume", 15, -31, 1, 0);
    tick(13); look("lock_held", 15, -31, 1, 0);
    tick(1);  look("lock_done", 15, -31, 2, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
